// File: rtl/sc_speed_timer_pkg.sv
// Shared constants and types for the speed-banded game timer.
// Thresholds are inclusive upper speed bounds of bands 0..2.
package sc_speed_timer_pkg;

  localparam int BAND_COUNT = 4;

  localparam int TH0_DEF = 10;
  localparam int TH1_DEF = 17;
  localparam int TH2_DEF = 32;

  localparam int DIV0_DEF = 17500000;
  localparam int DIV1_DEF = 0;
  localparam int DIV2_DEF = 14000000;
  localparam int DIV3_DEF = 10000000;

  typedef logic [$clog2(BAND_COUNT)-1:0] band_t;

endpackage

// File: rtl/sc_speed_timer_prescaler.sv
// Clock prescaler: counts 0..divisor-1 while enabled, pulses tick on wrap.
// A zero divisor stalls the count; clear restarts the period.
module sc_band_prescaler #(
  parameter int DIV_WIDTH = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_d, cnt_q;
  logic                 tick_d, tick_q;
  logic                 last;

  assign last = (cnt_q == divisor - DIV_WIDTH'(1));
  assign tick = tick_q;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && divisor != '0) begin
      if (last) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/sc_speed_timer.sv
// Game-time down-counter whose tick rate follows the vehicle speed band.
// Band changes and loads restart the prescaler period.
import sc_speed_timer_pkg::*;

module sc_speed_timer #(
  parameter int SPEED_WIDTH = 8,
  parameter int TIME_WIDTH  = 8,
  parameter int DIV_WIDTH   = 26,
  parameter int TH0         = TH0_DEF,
  parameter int TH1         = TH1_DEF,
  parameter int TH2         = TH2_DEF,
  parameter int DIV0        = DIV0_DEF,
  parameter int DIV1        = DIV1_DEF,
  parameter int DIV2        = DIV2_DEF,
  parameter int DIV3        = DIV3_DEF
) (
  input  logic                   SC_RegGENERAL_CLOCK_50,
  input  logic                   SC_RegGENERAL_RESET_InHigh,
  input  logic [SPEED_WIDTH-1:0] speed_InBUS,
  input  logic                   run_InHigh,
  input  logic                   load_InHigh,
  input  logic [TIME_WIDTH-1:0]  loadValue_InBUS,
  output logic                   tick_OutHigh,
  output logic [TIME_WIDTH-1:0]  time_OutBUS,
  output logic [1:0]             band_OutBUS,
  output logic                   expired_OutHigh
);

  localparam logic [SPEED_WIDTH-1:0] T0 = SPEED_WIDTH'(TH0);
  localparam logic [SPEED_WIDTH-1:0] T1 = SPEED_WIDTH'(TH1);
  localparam logic [SPEED_WIDTH-1:0] T2 = SPEED_WIDTH'(TH2);

  band_t                 band_d, band_q;
  logic [TIME_WIDTH-1:0] time_d, time_q;
  logic                  exp_d, exp_q;
  logic [DIV_WIDTH-1:0]  div;
  logic                  tick;
  logic                  pre_clr;

  always_comb begin
    band_d = 2'd3;
    unique case (1'b1)
      (speed_InBUS <= T0):                      band_d = 2'd0;
      (speed_InBUS > T0 && speed_InBUS <= T1): band_d = 2'd1;
      (speed_InBUS > T1 && speed_InBUS <= T2): band_d = 2'd2;
      (speed_InBUS > T2):                       band_d = 2'd3;
    endcase
  end

  always_comb begin
    div = DIV_WIDTH'(DIV3);
    unique case (band_q)
      2'd0: div = DIV_WIDTH'(DIV0);
      2'd1: div = DIV_WIDTH'(DIV1);
      2'd2: div = DIV_WIDTH'(DIV2);
      2'd3: div = DIV_WIDTH'(DIV3);
    endcase
  end

  assign pre_clr = load_InHigh || (band_d != band_q);

  sc_band_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_pre (
    .clk     (SC_RegGENERAL_CLOCK_50),
    .rst     (SC_RegGENERAL_RESET_InHigh),
    .enable  (run_InHigh),
    .clear   (pre_clr),
    .divisor (div),
    .tick    (tick)
  );

  // Load wins over a coincident tick; expiry needs a real 1->0 step.
  always_comb begin
    time_d = time_q;
    exp_d  = exp_q;
    if (load_InHigh) begin
      time_d = loadValue_InBUS;
      exp_d  = 1'b0;
    end else if (tick && run_InHigh && time_q != '0) begin
      time_d = time_q - TIME_WIDTH'(1);
      if (time_q == TIME_WIDTH'(1)) exp_d = 1'b1;
    end
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or
              posedge SC_RegGENERAL_RESET_InHigh) begin
    if (SC_RegGENERAL_RESET_InHigh) begin
      band_q <= '0;
      time_q <= '0;
      exp_q  <= 1'b0;
    end else begin
      band_q <= band_d;
      time_q <= time_d;
      exp_q  <= exp_d;
    end
  end

  assign tick_OutHigh    = tick;
  assign time_OutBUS     = time_q;
  assign band_OutBUS     = band_q;
  assign expired_OutHigh = exp_q;

endmodule

// File: tb/tb_sc_speed_timer.sv
// Scoreboard bench for sc_speed_timer against a period-arithmetic model.
// Directed scenarios first, then randomized traffic.
module tb_sc_speed_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] speed = '0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic [7:0] lv = '0;
  logic       tick;
  logic [7:0] tim;
  logic [1:0] band;
  logic       expd;

  sc_speed_timer #(
    .SPEED_WIDTH(8), .TIME_WIDTH(8), .DIV_WIDTH(8),
    .TH0(10), .TH1(17), .TH2(32),
    .DIV0(4), .DIV1(0), .DIV2(3), .DIV3(2)
  ) dut (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_RESET_InHigh (rst),
    .speed_InBUS                (speed),
    .run_InHigh                 (run),
    .load_InHigh                (load),
    .loadValue_InBUS            (lv),
    .tick_OutHigh               (tick),
    .time_OutBUS                (tim),
    .band_OutBUS                (band),
    .expired_OutHigh            (expd)
  );

  always #10 clk = ~clk;

  typedef struct {
    int tick;
    int tim;
    int band;
    int expd;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;

  int divs[4] = '{4, 0, 3, 2};
  int m_band = 0, m_runs = 0, m_tick = 0;
  int m_time = 0, m_exp = 0;

  task automatic check(string nm, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  function automatic int band_of(int s);
    if (s <= 10) return 0;
    if (s <= 17) return 1;
    if (s <= 32) return 2;
    return 3;
  endfunction

  // m_runs counts enabled clocks since the period restarted;
  // a tick falls on every multiple of the band divisor.
  function automatic void model_edge(int s, int r, int l, int v, int rr);
    int b, d, nt;
    if (rr != 0) begin
      m_band = 0; m_runs = 0; m_tick = 0; m_time = 0; m_exp = 0;
      return;
    end
    b  = band_of(s);
    d  = divs[m_band];
    nt = 0;
    if (l != 0 || b != m_band) begin
      m_runs = 0;
    end else if (r != 0 && d > 0) begin
      m_runs = m_runs + 1;
      nt = (m_runs % d == 0) ? 1 : 0;
    end
    if (l != 0) begin
      m_time = v;
      m_exp  = 0;
    end else if (m_tick != 0 && r != 0 && m_time > 0) begin
      m_time = m_time - 1;
      if (m_time == 0) m_exp = 1;
    end
    m_band = b;
    m_tick = nt;
  endfunction

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      cur = sbq.pop_front();
      check("tick", int'(tick), cur.tick);
      check("time", int'(tim), cur.tim);
      check("band", int'(band), cur.band);
      check("expired", int'(expd), cur.expd);
    end
  end

  task automatic step(int s, int r, int l, int v, int rr);
    exp_t e;
    @(negedge clk);
    speed = 8'(s);
    run   = r[0];
    load  = l[0];
    lv    = 8'(v);
    if (rr != 0 && !rst) begin
      rst = 1'b1;
      #1;
      check("rst_tick", int'(tick), 0);
      check("rst_time", int'(tim), 0);
      check("rst_band", int'(band), 0);
      check("rst_expired", int'(expd), 0);
    end
    rst = rr[0];
    model_edge(s, r, l, v, rr);
    e.tick = m_tick;
    e.tim  = m_time;
    e.band = m_band;
    e.expd = m_exp;
    sbq.push_back(e);
  endtask

  task automatic idle(int n, int s, int r);
    for (int i = 0; i < n; i++) step(s, r, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    // countdown to expiry in band 0
    step(5, 1, 1, 3, 0);
    idle(20, 5, 1);
    // stall band
    step(12, 1, 1, 9, 0);
    idle(20, 12, 1);
    // band change mid-count
    step(5, 1, 1, 9, 0);
    idle(6, 5, 1);
    idle(9, 50, 1);
    // loads aligned with band-3 ticks
    step(50, 1, 1, 7, 0);
    idle(1, 50, 1);
    step(50, 1, 1, 7, 0);
    idle(3, 50, 1);
    step(50, 1, 1, 7, 0);
    idle(4, 50, 1);
    // run pause mid-period
    step(5, 1, 1, 9, 0);
    idle(2, 5, 1);
    idle(10, 5, 0);
    idle(8, 5, 1);
    // reset mid-count
    step(5, 1, 1, 5, 0);
    idle(6, 5, 1);
    step(5, 1, 0, 0, 1);
    step(5, 1, 0, 0, 1);
    idle(10, 5, 1);
    // load 0: no expiry event
    step(50, 1, 1, 0, 0);
    idle(5, 50, 1);
    for (int i = 0; i < 500; i++) begin
      int s, r, l, v, rr;
      s  = $urandom_range(0, 40);
      if ($urandom_range(0, 7) != 0) s = speed;
      r  = ($urandom_range(0, 5) != 0) ? 1 : 0;
      l  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      v  = $urandom_range(0, 6);
      rr = ($urandom_range(0, 99) == 0) ? 1 : 0;
      step(s, r, l, v, rr);
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
